// File: rtl/fifo_stat.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky
// error flags, synchronous flush and a selectable FWFT / registered read port.
module fifo_stat #(
    parameter int B         = 8,
    parameter int W         = 4,
    parameter int AE_THRESH = 2,
    parameter int AF_THRESH = 14,
    parameter int FWFT      = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         rd,
    input  logic         flush,
    input  logic         clr_err,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam int         D      = 2 ** W;
    localparam logic [W:0] DEPTH  = (W + 1)'(D);
    localparam logic [W:0] AE_LVL = (W + 1)'(AE_THRESH);
    localparam logic [W:0] AF_LVL = (W + 1)'(AF_THRESH);

    logic [B-1:0] mem [D];
    logic [W-1:0] w_ptr;
    logic [W-1:0] r_ptr;
    logic         wr_acc;
    logic         rd_acc;
    logic [W:0]   next_count;
    logic         ovf_set;
    logic         udf_set;

    // A write into a full FIFO is still accepted when a read frees the head slot.
    always_comb begin
        rd_acc     = rd & ~empty;
        wr_acc     = wr & (~full | rd_acc);
        next_count = count;
        if (flush)
            next_count = '0;
        else if (wr_acc & ~rd_acc)
            next_count = count + 1'b1;
        else if (rd_acc & ~wr_acc)
            next_count = count - 1'b1;
        ovf_set = ~flush & wr & full & ~rd;
        udf_set = ~flush & rd & empty;
    end

    // Flags are registered from next_count so no input reaches them combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_LVL == '0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (flush) begin
                w_ptr <= '0;
                r_ptr <= '0;
            end else begin
                if (wr_acc)
                    w_ptr <= w_ptr + 1'b1;
                if (rd_acc)
                    r_ptr <= r_ptr + 1'b1;
            end
            count        <= next_count;
            empty        <= (next_count == '0);
            full         <= (next_count == DEPTH);
            almost_empty <= (next_count <= AE_LVL);
            almost_full  <= (next_count >= AF_LVL);
            overflow     <= ovf_set | (overflow & ~clr_err);
            underflow    <= udf_set | (underflow & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc & ~flush)
            mem[w_ptr] <= w_data;
    end

    // On a full simultaneous read/write the read sees the old head before it is overwritten.
    generate
        if (FWFT != 0) begin : g_fwft
            assign r_data = mem[r_ptr];
        end else begin : g_reg
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_data <= '0;
                else if (rd_acc & ~flush)
                    r_data <= mem[r_ptr];
            end
        end
    endgenerate

endmodule
